fregister_mp: RTL and testbench
===============================

// Module: fregister_mp
// PURPOSE
//  Next-generation FP register file: NRP registered read ports, two write ports (FPU, load unit),
//  same-cycle write->read bypass, hardwired constant region and per-register busy scoreboard for
//  multi-cycle FPU ops. Sits between decode (reads/issue) and write-back; raises a hazard to stall decode.
// PARAMETERS
//  XLEN     32  data width
//  NREG     32  register count (power of 2)
//  AW       5   address width, log2(NREG)
//  NRP      3   read ports (rs1, rs2, rs3 for fused mul-add)
//  CONST_LO 11  first read-only constant register
//  CONST_HI 29  last read-only constant register
// PORTS
//  clk       in   1          clock
//  rst_n     in   1          async active-low reset
//  d_en      in   1          decode-stage enable
//  rs_addr   in   NRP*AW     read addresses, port i at [i*AW +: AW]
//  rs_vld    in   NRP        read port i used by current instruction
//  E_frs     out  NRP*XLEN   registered read data, port i at [i*XLEN +: XLEN]
//  hazard    out  1          comb: a used source is busy and not written this cycle
//  iss_en    in   1          issue of long-latency op writing iss_rd
//  iss_rd    in   AW         destination of issued op
//  we0/we1   in   1          write enable, port 0 (FPU) / port 1 (load)
//  wa0/wa1   in   AW         write addresses
//  wd0/wd1   in   XLEN       write data
//  flush     in   1          sync clear of all busy bits (pipeline flush)
// BEHAVIOUR
//  Reset (rst_n=0, async): E_frs=0, all busy=0, writable regs=0; constants hardwired, unaffected.
//  Writable set W: addr!=0 and (addr<CONST_LO or addr>CONST_HI). f0 reads 0 always.
//  Constants (NREG=32 defaults): f11..f20 = 1.0,2.0,4.0,10.0,15.0,20.0,128.0,200.0,255.0,850.0;
//   f21..f29 = 0.1,0.2,0.001,0.005,0.15,0.25,0.5,pi,30/pi (0x3F800000..0x4118C9EB, IEEE-754 single).
//  Write: weN && waN in W -> reg updated at clk edge. Writes outside W ignored (no effect, no busy clear).
//  Both ports same addr same cycle: port 1 (load) wins data.
//  Read: 1-cycle latency. On edge with d_en=1 && hazard=0, E_frs[i] <= value(rs_addr[i]).
//   d_en=0 or hazard=1: E_frs holds.
//  Bypass: value(a) = wd1 if we1&&wa1==a&&a in W, else wd0 if we0&&wa0==a&&a in W, else array/const.
//  Scoreboard busy[NREG]: set at edge if iss_en && d_en && !hazard && iss_rd in W;
//   cleared at edge by any accepted write (we0/we1 in W) to that addr.
//   Set and clear same addr same cycle: set wins (new producer). flush=1: all busy cleared,
//   flush dominates set. Busy never set for f0 or constants.
//  hazard = OR_i( rs_vld[i] && busy[rs_addr[i]] && !(write to rs_addr[i] this cycle) ).
//   Unused ports (rs_vld=0) never cause hazard. Also covers WAW: iss_rd busy -> hazard.
//  Reset mid-operation: busy bits and pending state lost immediately; no spurious writes.
// TESTING
//  1 Reset, read f11,f28,f0 with d_en -> next cycle E_frs = 0x3F800000,0x40490FDB,0x00000000.
//  2 we0 wa0=5 wd0=0x40400000, same cycle read rs=5 d_en -> E_frs[0]=0x40400000 (bypass);
//    we0 wa0=15 wd0=1 -> later read f15 still 0x41700000.
//  3 iss_en iss_rd=3; next cycle read f3 rs_vld=1 -> hazard=1, E_frs held; we0 wa0=3 wd0=0x3F000000
//    -> hazard=0 same cycle, E_frs[i]=0x3F000000, busy[3] cleared.
//  4 we0 wa0=7 wd0=A and we1 wa1=7 wd1=B same cycle -> f7=B; iss_en rd=8 plus write to 8 same cycle
//    -> busy[8]=1 remains.
//  5 busy[4] set, rs_vld=0 on that port -> hazard=0; flush=1 -> all busy=0.
//  6 Assert rst_n=0 mid-stream (async, off clock edge) -> E_frs=0, busy=0 immediately.

Source files
------------

// File: rtl/fregister_mp.sv
// rtl/fregister_mp.sv - FP register file: NRP read ports, two write ports, bypass, constants, busy scoreboard
module fregister_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int NRP      = 3,
    parameter int CONST_LO = 11,
    parameter int CONST_HI = 29
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                d_en,
    input  logic [NRP*AW-1:0]   rs_addr,
    input  logic [NRP-1:0]      rs_vld,
    output logic [NRP*XLEN-1:0] E_frs,
    output logic                hazard,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic                flush
);

    localparam logic [AW-1:0] LO = AW'(CONST_LO);
    localparam logic [AW-1:0] HI = AW'(CONST_HI);

    logic [XLEN-1:0]     r_regs [NREG];
    logic [NREG-1:0]     r_busy;
    logic [NRP*XLEN-1:0] r_efrs;

    logic                w_wr0;
    logic                w_wr1;
    logic                w_accept;
    logic                w_set;
    logic                w_hazard;
    logic [XLEN-1:0]     w_rd_val [NRP];

    // Writable registers: everything except f0 and the hardwired constant window.
    function automatic logic in_w(input logic [AW-1:0] a);
        return (a != '0) && ((a < LO) || (a > HI));
    endfunction

    // Hardwired IEEE-754 single constants for f11..f29.
    function automatic logic [XLEN-1:0] const_val(input logic [AW-1:0] a);
        logic [31:0] v;
        case (int'(a))
            11:      v = 32'h3F800000;  // 1.0
            12:      v = 32'h40000000;  // 2.0
            13:      v = 32'h40800000;  // 4.0
            14:      v = 32'h41200000;  // 10.0
            15:      v = 32'h41700000;  // 15.0
            16:      v = 32'h41A00000;  // 20.0
            17:      v = 32'h43000000;  // 128.0
            18:      v = 32'h43480000;  // 200.0
            19:      v = 32'h437F0000;  // 255.0
            20:      v = 32'h44548000;  // 850.0
            21:      v = 32'h3DCCCCCD;  // 0.1
            22:      v = 32'h3E4CCCCD;  // 0.2
            23:      v = 32'h3A83126F;  // 0.001
            24:      v = 32'h3BA3D70A;  // 0.005
            25:      v = 32'h3E19999A;  // 0.15
            26:      v = 32'h3E800000;  // 0.25
            27:      v = 32'h3F000000;  // 0.5
            28:      v = 32'h40490FDB;  // pi
            29:      v = 32'h4118C9EB;  // 30/pi
            default: v = 32'h00000000;
        endcase
        return XLEN'(v);
    endfunction

    assign w_wr0    = we0 && in_w(wa0);
    assign w_wr1    = we1 && in_w(wa1);
    assign w_accept = d_en && !w_hazard;
    assign w_set    = iss_en && w_accept && in_w(iss_rd);
    assign hazard   = w_hazard;
    assign E_frs    = r_efrs;

    // Per-port read value with same-cycle bypass; the load port has priority over the FPU port.
    always_comb begin
        for (int i = 0; i < NRP; i++) begin
            logic [AW-1:0] a;
            a = rs_addr[i*AW +: AW];
            w_rd_val[i] = '0;
            if (w_wr1 && (wa1 == a))
                w_rd_val[i] = wd1;
            else if (w_wr0 && (wa0 == a))
                w_rd_val[i] = wd0;
            else if (in_w(a))
                w_rd_val[i] = r_regs[a];
            else
                w_rd_val[i] = const_val(a);
        end
    end

    // Stall when a used source (or the issuing destination, for WAW) is busy and not being written now.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < NRP; i++) begin
            logic [AW-1:0] a;
            a = rs_addr[i*AW +: AW];
            if (rs_vld[i] && r_busy[a] && !((w_wr0 && wa0 == a) || (w_wr1 && wa1 == a)))
                w_hazard = 1'b1;
        end
        if (iss_en && r_busy[iss_rd] && !((w_wr0 && wa0 == iss_rd) || (w_wr1 && wa1 == iss_rd)))
            w_hazard = 1'b1;
    end

    // Register array; port 1 is written last so it wins on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++)
                r_regs[r] <= '0;
        end else begin
            if (w_wr0)
                r_regs[wa0] <= wd0;
            if (w_wr1)
                r_regs[wa1] <= wd1;
        end
    end

    // Busy scoreboard: flush clears everything, a new producer beats a retiring write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (w_set && (int'(iss_rd) == r))
                    r_busy[r] <= 1'b1;
                else if ((w_wr0 && int'(wa0) == r) || (w_wr1 && int'(wa1) == r))
                    r_busy[r] <= 1'b0;
            end
        end
    end

    // Registered read data, advanced only when decode proceeds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_efrs <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < NRP; i++)
                r_efrs[i*XLEN +: XLEN] <= w_rd_val[i];
        end
    end

endmodule

// File: tb/tb_fregister_mp.sv
// tb/tb_fregister_mp.sv - directed self-checking bench for fregister_mp
module tb_fregister_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_en;
    logic [14:0] rs_addr;
    logic [2:0]  rs_vld;
    logic [95:0] E_frs;
    logic        hazard;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        flush;

    int checks = 0;
    int errors = 0;

    logic [31:0] const_tbl [19] = '{
        32'h3F800000, 32'h40000000, 32'h40800000, 32'h41200000, 32'h41700000,
        32'h41A00000, 32'h43000000, 32'h43480000, 32'h437F0000, 32'h44548000,
        32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3A83126F, 32'h3BA3D70A, 32'h3E19999A,
        32'h3E800000, 32'h3F000000, 32'h40490FDB, 32'h4118C9EB
    };

    fregister_mp dut (
        .clk(clk), .rst_n(rst_n), .d_en(d_en), .rs_addr(rs_addr), .rs_vld(rs_vld),
        .E_frs(E_frs), .hazard(hazard), .iss_en(iss_en), .iss_rd(iss_rd),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1), .flush(flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] e(input int i);
        return E_frs[i*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rs(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        rs_addr = {a2, a1, a0};
    endtask

    initial begin
        rst_n = 1'b0; d_en = 1'b0; rs_addr = '0; rs_vld = '0; iss_en = 1'b0; iss_rd = '0;
        we0 = 1'b0; wa0 = '0; wd0 = '0; we1 = 1'b0; wa1 = '0; wd1 = '0; flush = 1'b0;
        repeat (2) tick();
        chk("reset_e0", e(0), 32'h0);
        chk("reset_e1", e(1), 32'h0);
        chk("reset_e2", e(2), 32'h0);
        chk("reset_hazard", {31'b0, hazard}, 32'h0);
        rst_n = 1'b1;

        // constant and f0 reads
        set_rs(5'd11, 5'd28, 5'd0); rs_vld = 3'b111; d_en = 1'b1;
        tick();
        chk("t1_f11", e(0), 32'h3F800000);
        chk("t1_f28", e(1), 32'h40490FDB);
        chk("t1_f0", e(2), 32'h0);
        for (int k = 11; k <= 29; k++) begin
            set_rs(5'(k), 5'd0, 5'(40 - k));
            tick();
            chk($sformatf("const_f%0d", k), e(0), const_tbl[k - 11]);
            chk($sformatf("const_f%0d", 40 - k), e(2), const_tbl[29 - k]);
        end

        // bypass, write to constant ignored, write to f0 ignored
        set_rs(5'd5, 5'd0, 5'd0); we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h40400000;
        tick();
        chk("t2_bypass_f5", e(0), 32'h40400000);
        set_rs(5'd15, 5'd0, 5'd0); wa0 = 5'd15; wd0 = 32'h00000001;
        tick();
        chk("t2_const_f15_bypass", e(0), 32'h41700000);
        set_rs(5'd5, 5'd15, 5'd0); wa0 = 5'd0; wd0 = 32'hDEADBEEF;
        tick();
        chk("t2_f5_array", e(0), 32'h40400000);
        chk("t2_f15_kept", e(1), 32'h41700000);
        chk("t2_f0_zero", e(2), 32'h0);

        // scoreboard hazard and clear by write
        we0 = 1'b0; iss_en = 1'b1; iss_rd = 5'd3; rs_vld = 3'b000;
        tick();
        iss_en = 1'b0; set_rs(5'd3, 5'd3, 5'd3); rs_vld = 3'b111;
        #1 chk("t3_hazard_set", {31'b0, hazard}, 32'h1);
        tick();
        chk("t3_held_e0", e(0), 32'h40400000);
        chk("t3_held_e1", e(1), 32'h41700000);
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h3F000000;
        #1 chk("t3_hazard_cleared_by_write", {31'b0, hazard}, 32'h0);
        tick();
        chk("t3_e0", e(0), 32'h3F000000);
        chk("t3_e1", e(1), 32'h3F000000);
        chk("t3_e2", e(2), 32'h3F000000);
        we0 = 1'b0;
        #1 chk("t3_busy_cleared", {31'b0, hazard}, 32'h0);

        // dual write collision, set wins over clear
        set_rs(5'd7, 5'd0, 5'd0); rs_vld = 3'b001;
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11111111;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22222222;
        tick();
        chk("t4_bypass_load_wins", e(0), 32'h22222222);
        we0 = 1'b0; we1 = 1'b0;
        tick();
        chk("t4_array_load_wins", e(0), 32'h22222222);
        rs_vld = 3'b000; iss_en = 1'b1; iss_rd = 5'd8;
        we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h12345678;
        tick();
        iss_en = 1'b0; we0 = 1'b0; set_rs(5'd8, 5'd0, 5'd0); rs_vld = 3'b001;
        #1 chk("t4_set_wins_busy8", {31'b0, hazard}, 32'h1);
        we1 = 1'b1; wa1 = 5'd8; wd1 = 32'h87654321;
        #1 chk("t4_load_clears_hazard", {31'b0, hazard}, 32'h0);
        tick();
        chk("t4_f8_bypass", e(0), 32'h87654321);
        we1 = 1'b0; rs_vld = 3'b000; iss_en = 1'b1; iss_rd = 5'd12;
        tick();
        iss_en = 1'b0; set_rs(5'd12, 5'd0, 5'd0); rs_vld = 3'b001;
        #1 chk("t4_const_never_busy", {31'b0, hazard}, 32'h0);
        tick();
        chk("t4_f12", e(0), 32'h40000000);

        // unused port, flush, flush beats set, WAW
        rs_vld = 3'b000; iss_en = 1'b1; iss_rd = 5'd4;
        tick();
        iss_en = 1'b0; set_rs(5'd0, 5'd4, 5'd0); rs_vld = 3'b101;
        #1 chk("t5_unused_port", {31'b0, hazard}, 32'h0);
        rs_vld = 3'b010;
        #1 chk("t5_used_port", {31'b0, hazard}, 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1 chk("t5_flush_clears", {31'b0, hazard}, 32'h0);
        rs_vld = 3'b000; iss_en = 1'b1; iss_rd = 5'd9; flush = 1'b1;
        tick();
        flush = 1'b0; iss_en = 1'b0; set_rs(5'd0, 5'd9, 5'd0); rs_vld = 3'b010;
        #1 chk("t5_flush_beats_set", {31'b0, hazard}, 32'h0);
        rs_vld = 3'b000; iss_en = 1'b1; iss_rd = 5'd6;
        tick();
        #1 chk("t5_waw_hazard", {31'b0, hazard}, 32'h1);
        iss_en = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;

        // asynchronous reset mid-stream
        set_rs(5'd9, 5'd0, 5'd0); rs_vld = 3'b001;
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hCAFEF00D; iss_en = 1'b1; iss_rd = 5'd10;
        tick();
        chk("t6_pre_reset_e0", e(0), 32'hCAFEF00D);
        we0 = 1'b0; iss_en = 1'b0; set_rs(5'd10, 5'd0, 5'd0);
        #1 chk("t6_busy10", {31'b0, hazard}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_e0", e(0), 32'h0);
        chk("t6_async_busy", {31'b0, hazard}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_rs(5'd9, 5'd0, 5'd0);
        tick();
        chk("t6_f9_cleared", e(0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
